// File: rtl/mem_pkg.sv
// Shared memory-access types: the access width encoding used by control and the
// load/store unit, the load/store unit state set, and width helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        BITS8  = 2'd0,
        BITS16 = 2'd1,
        BITS32 = 2'd2
    } MemWidth;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCESS   = 3'd1,
        DRAIN    = 3'd2,
        RESP     = 3'd3,
        ERR_RESP = 3'd4
    } LsuState;

    // Encoding 3 of the width field has no MemWidth member and is always rejected.
    localparam logic [1:0] WIDTH_RSVD = 2'd3;

    function automatic logic [2:0] width_bytes(input MemWidth w);
        case (w)
            BITS8:   return 3'd1;
            BITS16:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] last_index(input MemWidth w);
        case (w)
            BITS8:   return 2'd0;
            BITS16:  return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the control-side request/response handshake and the byte-wide RAM port
// of the load/store unit. "slave" is the unit's view, "master" is its environment.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    // req: a transfer happens on a clk edge where req_valid & req_ready are both 1;
    // req_valid and every req_* field stay stable until then. resp_valid is a
    // single-cycle strobe with no back-pressure; resp_err/resp_rdata are only
    // meaningful while it is high.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_width;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [31:0]           resp_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;

    modport slave (
        input  req_valid, req_we, req_width, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_width, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load word to 32 bits.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  width,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = raw;
        case (MemWidth'(width))
            BITS8:   rdata = is_unsigned ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            BITS16:  rdata = is_unsigned ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: rdata = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store stage: walks N = 1/2/4 bytes of a little-endian 8-bit RAM,
// assembles and extends loads, and returns a one-cycle done/err strobe.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 'hffff
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus,
    output LsuState            dbg_state
);

    LsuState               state, state_d;
    logic [1:0]            idx;
    logic                  we_q;
    logic [1:0]            width_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           data_q;
    logic [31:0]           ext_data;
    logic [1:0]            last_idx;
    logic [1:0]            cap_idx;
    logic [ADDR_WIDTH:0]   req_end;
    logic                  req_bad;
    logic                  accept;

    // One extra bit so an access wrapping past the top of the address space still errs.
    assign req_end = {1'b0, bus.req_addr}
                   + (ADDR_WIDTH+1)'(width_bytes(MemWidth'(bus.req_width)))
                   - (ADDR_WIDTH+1)'(1);
    assign req_bad  = (bus.req_width == WIDTH_RSVD) || (req_end > {1'b0, ADDR_LIMIT});
    assign accept   = bus.req_valid && (state == IDLE);
    assign last_idx = last_index(MemWidth'(width_q));
    assign cap_idx  = idx - 2'd1;
    assign dbg_state = state;

    load_extend u_extend (
        .raw         (data_q),
        .width       (width_q),
        .is_unsigned (uns_q),
        .rdata       (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d        = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'd0;
        bus.mem_addr   = '0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = 8'd0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = req_bad ? ERR_RESP : ACCESS;
            end
            ACCESS: begin
                bus.mem_addr  = addr_q + ADDR_WIDTH'(idx);
                bus.mem_we    = we_q;
                bus.mem_wdata = wdata_q[{idx, 3'b000} +: 8];
                if (idx == last_idx) state_d = we_q ? RESP : DRAIN;
            end
            DRAIN: state_d = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = ext_data;
                state_d        = IDLE;
            end
            ERR_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM read data lags the address by one cycle, so byte idx-1 lands while idx is driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= 2'd0;
            we_q    <= 1'b0;
            width_q <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
        end else if (accept) begin
            idx     <= 2'd0;
            we_q    <= bus.req_we;
            width_q <= bus.req_width;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            data_q  <= 32'd0;
        end else if (state == ACCESS) begin
            if (!we_q && idx != 2'd0) data_q[{cap_idx, 3'b000} +: 8] <= bus.mem_rdata;
            if (idx != last_idx) idx <= idx + 2'd1;
        end else if (state == DRAIN) begin
            data_q[{last_idx, 3'b000} +: 8] <= bus.mem_rdata;
        end
    end

endmodule
